// File: rtl/md_sched.sv
// md_sched - sequencing controller for the EX-stage multiply/divide units
// and the HI/LO write port.
//
// A mult/multu/div/divu request from EX is accepted only in IDLE. Its
// operands are latched and presented to the pipelined multiplier (fixed
// latency MUL_LAT) or to the iterative divider (level start, ready
// handshake). While the operation is in flight the pipeline is stalled.
// The 64-bit result is then written to HI/LO with a single-cycle strobe.
//
// Parameters:
//   MUL_LAT  cycles from mul operand presentation to a valid mul_result (1..15)
//   CNT_W    width of the multiply latency counter
//
// Optional feature (macro MD_DIVZERO_FAST_EN):
//   When defined, a div/divu whose divisor is zero bypasses the divider.
//   The result is HI=src_a, LO=32'hFFFF_FFFF, written one cycle after
//   acceptance, and div_start is never raised for it.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_valid, req_op    request from EX (00 mult, 01 multu, 10 div, 11 divu)
//   src_a, src_b         rs / rt operands
//   hold                 downstream stall, keeps the FSM in DONE
//   annul                flush of the in-flight operation
//   mul_*                latched operands to / result from the multiplier
//   div_*                handshake, operands and result of the divider
//   stallreq, busy       stall request to the pipeline, FSM-not-idle flag
//   hilo_we, hi/lo_wdata HI/LO write strobe and data
module md_sched #(
    parameter int MUL_LAT = 2,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [1:0]  req_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        hold,
    input  logic        annul,
    output logic        mul_signed,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_opdata1,
    output logic [31:0] div_opdata2,
    output logic        div_annul,
    input  logic        div_ready,
    input  logic [63:0] div_result,
    output logic        stallreq,
    output logic        busy,
    output logic        hilo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_WAIT = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       opa, opb;
    logic              op_signed;
    logic [31:0]       hi_r, lo_r;
    logic              first_done;
    logic              accept;
    logic              div_zero;

    // A request is taken only from IDLE, and a flush in the same cycle wins.
    assign accept = (state == IDLE) && req_valid && !annul;

`ifdef MD_DIVZERO_FAST_EN
    assign div_zero = req_op[1] && (src_b == 32'd0);
`else
    assign div_zero = 1'b0;
`endif

    // Both units see the latched operands for the whole operation.
    assign mul_signed  = op_signed;
    assign mul_ina     = opa;
    assign mul_inb     = opb;
    assign div_signed  = op_signed;
    assign div_opdata1 = opa;
    assign div_opdata2 = opb;
    assign hi_wdata    = hi_r;
    assign lo_wdata    = lo_r;

    // Next-state logic. annul returns any busy state to IDLE; req_valid is
    // not looked at outside IDLE so a stalled instruction cannot re-trigger.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!req_op[1])
                        state_nxt = MUL_WAIT;
                    else if (div_zero)
                        state_nxt = DONE;
                    else
                        state_nxt = DIV_WAIT;
                end
            end
            MUL_WAIT: begin
                if (annul)
                    state_nxt = IDLE;
                else if (cnt == CNT_W'(1))
                    state_nxt = DONE;
            end
            DIV_WAIT: begin
                if (annul)
                    state_nxt = IDLE;
                else if (div_ready)
                    state_nxt = DONE;
            end
            DONE: begin
                if (annul || !hold)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode. div_start falls in the cycle div_ready arrives so the
    // divider sees exactly one start interval; the stall is released as soon
    // as the result is in hand (DONE) or the operation is flushed.
    always_comb begin
        stallreq  = 1'b0;
        div_start = 1'b0;
        div_annul = 1'b0;
        hilo_we   = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE:     stallreq = accept;
            MUL_WAIT: stallreq = !annul;
            DIV_WAIT: begin
                stallreq  = !annul;
                div_start = !div_ready && !annul;
                div_annul = annul;
            end
            DONE:     hilo_we = first_done && !annul;
            default: ;
        endcase
    end

    // State, operand latches, latency counter and result capture.
    // first_done is high only in the cycle right after entering DONE, which
    // limits the HI/LO write to one strobe however long hold keeps us there.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            opa        <= '0;
            opb        <= '0;
            op_signed  <= 1'b0;
            hi_r       <= '0;
            lo_r       <= '0;
            first_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            first_done <= (state != DONE);

            if (accept) begin
                opa       <= src_a;
                opb       <= src_b;
                op_signed <= ~req_op[0];
                cnt       <= req_op[1] ? '0 : CNT_W'(MUL_LAT);
            end else if (state == MUL_WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end

            if (accept && div_zero) begin
                hi_r <= src_a;
                lo_r <= 32'hFFFF_FFFF;
            end else if ((state == MUL_WAIT) && !annul && (cnt == CNT_W'(1))) begin
                hi_r <= mul_result[63:32];
                lo_r <= mul_result[31:0];
            end else if ((state == DIV_WAIT) && !annul && div_ready) begin
                hi_r <= div_result[63:32];
                lo_r <= div_result[31:0];
            end
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched - directed self-checking bench for md_sched.
// Models a combinational multiplier (operands are held stable by the DUT)
// and an iterative divider that raises div_ready after div_start has been
// high for DIV_CYC consecutive cycles. Inputs change just after the falling
// edge and outputs are sampled 1 ns later, well away from the rising edge.
module tb_md_sched;

    localparam int MUL_LAT = 2;
    localparam int CNT_W   = 4;
    localparam int DIV_CYC = 33;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        hold = 1'b0;
    logic        annul = 1'b0;
    logic        mul_signed;
    logic [31:0] mul_ina, mul_inb;
    logic [63:0] mul_result;
    logic        div_start, div_signed, div_annul, div_ready;
    logic [31:0] div_opdata1, div_opdata2;
    logic [63:0] div_result = '0;
    logic        stallreq, busy, hilo_we;
    logic [31:0] hi_wdata, lo_wdata;

    logic        div_ready_force = 1'b0;
    int          div_cnt;
    int          vectors = 0;
    int          miscompares = 0;

    md_sched #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
        .src_a(src_a), .src_b(src_b), .hold(hold), .annul(annul),
        .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb),
        .mul_result(mul_result), .div_start(div_start), .div_signed(div_signed),
        .div_opdata1(div_opdata1), .div_opdata2(div_opdata2), .div_annul(div_annul),
        .div_ready(div_ready), .div_result(div_result), .stallreq(stallreq),
        .busy(busy), .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata)
    );

    always #5 clk = ~clk;

    // Multiplier model: full 64-bit product of the presented operands.
    always_comb begin
        if (mul_signed)
            mul_result = 64'($signed({{32{mul_ina[31]}}, mul_ina}) * $signed({{32{mul_inb[31]}}, mul_inb}));
        else
            mul_result = {32'd0, mul_ina} * {32'd0, mul_inb};
    end

    // Divider model: counts cycles of div_start, result ready after DIV_CYC.
    always @(posedge clk) begin
        if (rst || !div_start) div_cnt <= 0;
        else                   div_cnt <= div_cnt + 1;
    end
    assign div_ready = (div_cnt == DIV_CYC) || div_ready_force;

    // Issue one request and run until the HI/LO write or max_cyc cycles.
    // lat is the cycle index of the write relative to acceptance (-1 if none).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int max_cyc, output int lat, output int stalls,
                          output int starts, output logic [31:0] hi_seen, output logic [31:0] lo_seen);
        lat = -1; stalls = 0; starts = 0; hi_seen = '0; lo_seen = '0;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; src_a = a; src_b = b;
        for (int i = 0; i < max_cyc; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (stallreq) stalls++;
            if (div_start) starts++;
            if (hilo_we) begin
                lat = i; hi_seen = hi_wdata; lo_seen = lo_wdata;
                req_valid = 1'b0;
                break;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        vectors++; if (stallreq !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_stallreq got %b want 0", stallreq); end
        vectors++; if (hilo_we !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_hilo_we got %b want 0", hilo_we); end
        vectors++; if (div_start !== 1'b0 || div_annul !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_div got start=%b annul=%b want 0/0", div_start, div_annul); end
        vectors++; if ({hi_wdata, lo_wdata} !== 64'd0) begin miscompares++; $display("[TB] FAIL reset_hilo got %h_%h want 0", hi_wdata, lo_wdata); end
        vectors++; if ({mul_ina, mul_inb} !== 64'd0) begin miscompares++; $display("[TB] FAIL reset_operands got %h_%h want 0", mul_ina, mul_inb); end
        rst = 1'b0;
        @(negedge clk); #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL post_reset_busy got %b want 0", busy); end
    endtask

    task automatic test_multu();
        int lat, stalls, starts, extra;
        logic [31:0] hi, lo;
        run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 20, lat, stalls, starts, hi, lo);
        vectors++; if (lat !== MUL_LAT + 1) begin miscompares++; $display("[TB] FAIL multu_latency got %0d want %0d", lat, MUL_LAT + 1); end
        vectors++; if (stalls !== 3) begin miscompares++; $display("[TB] FAIL multu_stall_cycles got %0d want 3", stalls); end
        vectors++; if (hi !== 32'h1) begin miscompares++; $display("[TB] FAIL multu_hi got %h want 00000001", hi); end
        vectors++; if (lo !== 32'hFFFF_FFFE) begin miscompares++; $display("[TB] FAIL multu_lo got %h want fffffffe", lo); end
        extra = 0;
        repeat (4) begin @(negedge clk); #1; if (hilo_we) extra++; end
        vectors++; if (extra !== 0) begin miscompares++; $display("[TB] FAIL multu_extra_writes got %0d want 0", extra); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL multu_idle got busy=%b want 0", busy); end
    endtask

    task automatic test_mult_neg();
        int lat, stalls, starts, extra;
        logic [31:0] hi, lo;
        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 20, lat, stalls, starts, hi, lo);
        vectors++; if (lat !== MUL_LAT + 1) begin miscompares++; $display("[TB] FAIL mult_latency got %0d want %0d", lat, MUL_LAT + 1); end
        vectors++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin miscompares++; $display("[TB] FAIL mult_result got %h_%h want ffffffff_fffffff1", hi, lo); end
        vectors++; if (mul_signed !== 1'b1) begin miscompares++; $display("[TB] FAIL mult_signed got %b want 1", mul_signed); end
        extra = 0;
        repeat (4) begin @(negedge clk); #1; if (hilo_we) extra++; end
        vectors++; if (extra !== 0) begin miscompares++; $display("[TB] FAIL mult_extra_writes got %0d want 0", extra); end
    endtask

    task automatic test_div();
        int lat, stalls, starts;
        logic [31:0] hi, lo;
        div_result = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 60, lat, stalls, starts, hi, lo);
        vectors++; if (starts !== 33) begin miscompares++; $display("[TB] FAIL div_start_cycles got %0d want 33", starts); end
        vectors++; if (lat !== 35) begin miscompares++; $display("[TB] FAIL div_latency got %0d want 35", lat); end
        vectors++; if (stalls !== 35) begin miscompares++; $display("[TB] FAIL div_stall_cycles got %0d want 35", stalls); end
        vectors++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin miscompares++; $display("[TB] FAIL div_result got %h_%h want ffffffff_fffffffd", hi, lo); end
        vectors++; if (div_signed !== 1'b1 || div_opdata1 !== 32'hFFFF_FFF9 || div_opdata2 !== 32'd2) begin miscompares++; $display("[TB] FAIL div_operands got s=%b %h/%h want 1 fffffff9/00000002", div_signed, div_opdata1, div_opdata2); end
        @(negedge clk); #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL div_idle got busy=%b want 0", busy); end
    endtask

    task automatic test_divzero();
        int lat, stalls, starts;
        logic [31:0] hi, lo;
        div_result = {32'h0000_0010, 32'hFFFF_FFFF};
        run_op(2'b10, 32'h0000_0010, 32'd0, 60, lat, stalls, starts, hi, lo);
`ifdef MD_DIVZERO_FAST_EN
        vectors++; if (starts !== 0) begin miscompares++; $display("[TB] FAIL divzero_start got %0d want 0", starts); end
        vectors++; if (lat !== 1) begin miscompares++; $display("[TB] FAIL divzero_latency got %0d want 1", lat); end
`else
        vectors++; if (starts !== 33) begin miscompares++; $display("[TB] FAIL divzero_start got %0d want 33", starts); end
        vectors++; if (lat !== 35) begin miscompares++; $display("[TB] FAIL divzero_latency got %0d want 35", lat); end
`endif
        vectors++; if (hi !== 32'h10 || lo !== 32'hFFFF_FFFF) begin miscompares++; $display("[TB] FAIL divzero_result got %h_%h want 00000010_ffffffff", hi, lo); end
        @(negedge clk); #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL divzero_idle got busy=%b want 0", busy); end
    endtask

    task automatic test_annul();
        int pulses, writes;
        pulses = 0; writes = 0;
        // divu flushed on cycle 10 after acceptance
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b11; src_a = 32'd100; src_b = 32'd7;
        #1;
        repeat (9) begin @(negedge clk); #1; if (div_annul) pulses++; if (hilo_we) writes++; end
        vectors++; if (busy !== 1'b1 || div_start !== 1'b1) begin miscompares++; $display("[TB] FAIL annul_pre got busy=%b start=%b want 1/1", busy, div_start); end
        @(negedge clk); annul = 1'b1; req_valid = 1'b0; #1;
        vectors++; if (div_annul !== 1'b1) begin miscompares++; $display("[TB] FAIL annul_div_annul got %b want 1", div_annul); end
        vectors++; if (stallreq !== 1'b0 || hilo_we !== 1'b0) begin miscompares++; $display("[TB] FAIL annul_cycle got stall=%b we=%b want 0/0", stallreq, hilo_we); end
        @(negedge clk); annul = 1'b0; #1;
        vectors++; if (busy !== 1'b0 || div_annul !== 1'b0) begin miscompares++; $display("[TB] FAIL annul_after got busy=%b annul=%b want 0/0", busy, div_annul); end
        @(negedge clk); div_ready_force = 1'b1; #1; if (hilo_we) writes++;
        @(negedge clk); div_ready_force = 1'b0; #1; if (hilo_we) writes++;
        vectors++; if (writes !== 0 || pulses !== 0 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL annul_late_ready got writes=%0d early_pulses=%0d busy=%b want 0/0/0", writes, pulses, busy); end
        // mult flushed in MUL_WAIT: no write, no divider abort
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b00; src_a = 32'd9; src_b = 32'd9;
        @(negedge clk); annul = 1'b1; req_valid = 1'b0; #1;
        vectors++; if (stallreq !== 1'b0 || div_annul !== 1'b0 || hilo_we !== 1'b0) begin miscompares++; $display("[TB] FAIL annul_mul got stall=%b dannul=%b we=%b want 0/0/0", stallreq, div_annul, hilo_we); end
        @(negedge clk); annul = 1'b0;
        writes = 0;
        repeat (4) begin #1; if (hilo_we) writes++; @(negedge clk); end
        #1;
        vectors++; if (writes !== 0 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL annul_mul_after got writes=%0d busy=%b want 0/0", writes, busy); end
        // annul in IDLE blocks acceptance
        @(negedge clk); req_valid = 1'b1; req_op = 2'b01; annul = 1'b1; #1;
        vectors++; if (stallreq !== 1'b0) begin miscompares++; $display("[TB] FAIL annul_idle_stall got %b want 0", stallreq); end
        @(negedge clk); req_valid = 1'b0; annul = 1'b0; #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL annul_idle_accept got busy=%b want 0", busy); end
    endtask

    task automatic test_hold();
        int lat, stalls, starts;
        logic [31:0] hi, lo;
        run_op(2'b00, 32'd6, 32'd7, 20, lat, stalls, starts, hi, lo);
        vectors++; if (lat !== MUL_LAT + 1 || hi !== 32'd0 || lo !== 32'h2A) begin miscompares++; $display("[TB] FAIL hold_write got lat=%0d %h_%h want 3 00000000_0000002a", lat, hi, lo); end
        // stay in DONE with the same instruction still presented by EX
        hold = 1'b1; req_valid = 1'b1; req_op = 2'b00; src_a = 32'd6; src_b = 32'd7;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk); #1;
            vectors++; if (hilo_we !== 1'b0 || busy !== 1'b1 || stallreq !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_cycle%0d got we=%b busy=%b stall=%b want 0/1/0", k, hilo_we, busy, stallreq); end
            vectors++; if (hi_wdata !== 32'd0 || lo_wdata !== 32'h2A) begin miscompares++; $display("[TB] FAIL hold_data%0d got %h_%h want 00000000_0000002a", k, hi_wdata, lo_wdata); end
            if (k == 3) begin hold = 1'b0; req_valid = 1'b0; end
        end
        @(negedge clk); #1;
        vectors++; if (busy !== 1'b0 || hilo_we !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_release got busy=%b we=%b want 0/0", busy, hilo_we); end
    endtask

    task automatic test_back_to_back();
        int lat, stalls, starts;
        logic [31:0] hi, lo;
        run_op(2'b01, 32'd3, 32'd4, 20, lat, stalls, starts, hi, lo);
        vectors++; if (lat !== 3 || hi !== 32'd0 || lo !== 32'd12) begin miscompares++; $display("[TB] FAIL b2b_first got lat=%0d %h_%h want 3 00000000_0000000c", lat, hi, lo); end
        run_op(2'b01, 32'h0001_0000, 32'h0001_0000, 20, lat, stalls, starts, hi, lo);
        vectors++; if (lat !== 3 || hi !== 32'd1 || lo !== 32'd0) begin miscompares++; $display("[TB] FAIL b2b_second got lat=%0d %h_%h want 3 00000001_00000000", lat, hi, lo); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b10; src_a = 32'd50; src_b = 32'd3;
        repeat (5) @(negedge clk);
        rst = 1'b1; req_valid = 1'b0;
        @(negedge clk); #1;
        vectors++; if (busy !== 1'b0 || div_start !== 1'b0 || stallreq !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mid_ctrl got busy=%b start=%b stall=%b want 0/0/0", busy, div_start, stallreq); end
        vectors++; if ({hi_wdata, lo_wdata, div_opdata1} !== 96'd0) begin miscompares++; $display("[TB] FAIL reset_mid_data got %h_%h op1=%h want 0", hi_wdata, lo_wdata, div_opdata1); end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult_neg();
        test_div();
        test_divzero();
        test_annul();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Sequencing controller for the EX-stage multiply/divide resources and the HI/LO write port.
- Accepts one mult/multu/div/divu request from EX and latches its operands.
- Drives the pipelined multiplier (fixed latency) and the iterative divider (start/ready handshake).
- Raises the EX stall request while the operation is in flight, then issues a single HI/LO write pulse with the 64-bit result.

Parameters:
- MUL_LAT, 2, cycles from mul operand presentation to valid mul_result (1..15).
- CNT_W, 4, width of the latency counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  EX holds a mult/multu/div/divu instruction
- req_op  in  2  00 mult, 01 multu, 10 div, 11 divu
- src_a  in  32  rs operand
- src_b  in  32  rt operand
- hold  in  1  downstream stall; EX cannot advance this cycle
- annul  in  1  kill the in-flight operation (flush)
- mul_signed  out  1  to multiplier
- mul_ina  out  32  to multiplier, latched operand
- mul_inb  out  32  to multiplier, latched operand
- mul_result  in  64  from multiplier
- div_start  out  1  level start to divider
- div_signed  out  1  to divider
- div_opdata1  out  32  dividend, latched
- div_opdata2  out  32  divisor, latched
- div_annul  out  1  abort pulse to divider
- div_ready  in  1  divider result valid
- div_result  in  64  {remainder, quotient}
- stallreq  out  1  stall request to the pipeline controller
- busy  out  1  FSM not IDLE
- hilo_we  out  1  one-cycle HI/LO write strobe
- hi_wdata  out  32  HI value
- lo_wdata  out  32  LO value

Behaviour:
- Reset: FSM=IDLE, counter=0, operand registers=0. All outputs 0: stallreq, hilo_we, div_start, div_annul, busy, hi/lo_wdata.
- States: IDLE, MUL_WAIT, DIV_WAIT, DONE.
- IDLE with req_valid=1 and annul=0:
  - Latch src_a, src_b, and signed=~req_op[0].
  - op[1]=0: go to MUL_WAIT, counter=MUL_LAT.
  - op[1]=1: go to DIV_WAIT.
  - stallreq=1 combinationally in this same cycle.
- MUL_WAIT:
  - mul_ina/inb/mul_signed driven from the latched registers.
  - Counter decrements each cycle. At counter==1, capture mul_result into hi/lo_wdata and go to DONE.
  - Total latency from acceptance to DONE = MUL_LAT+1 cycles.
- DIV_WAIT:
  - div_start=1 and operands held stable until div_ready=1.
  - On div_ready: capture div_result into hi/lo_wdata ({63:32}→HI, {31:0}→LO), drop div_start the same cycle, go to DONE.
- stallreq=1 in MUL_WAIT and DIV_WAIT. stallreq=0 in DONE.
- DONE:
  - hilo_we=1 only on the first DONE cycle.
  - hi/lo_wdata remain stable while in DONE.
  - hold=0: return to IDLE. hold=1: stay in DONE with hilo_we=0.
  - req_valid is ignored in DONE, so the same instruction does not re-trigger.
- annul in any non-IDLE state:
  - Return to IDLE next cycle, no hilo_we, stallreq=0 that cycle.
  - div_annul=1 for one cycle if the state was DIV_WAIT.
  - annul in IDLE blocks acceptance of a request that cycle.
- Simultaneous annul and div_ready: annul wins, no write.
- Reset mid-operation: immediate return to the reset state; the divider is reset by the same rst.
- Back-to-back ops: a new request is accepted only in IDLE, so a minimum 1-cycle IDLE gap is guaranteed by the DONE→IDLE transition.
- busy=1 in every state except IDLE.

Optional Feature:
- Macro: MD_DIVZERO_FAST_EN.
- Defined:
  - A div/divu accepted with src_b==0 skips DIV_WAIT and goes straight to DONE.
  - HI=src_a, LO=32'hFFFF_FFFF.
  - div_start is never asserted for it.
  - Latency from acceptance to the write is 1 cycle.
- Not defined: a divide by zero is sent to the divider like any other division, and the result is whatever the divider returns.

Test Plan:
- multu 0xFFFF_FFFF × 2, MUL_LAT=2 -> stallreq high 3 cycles; hilo_we pulses once; HI=0x1, LO=0xFFFF_FFFE.
- mult -3 × 5 -> HI=0xFFFF_FFFF, LO=0xFFFF_FFF1; no second write while req_valid is still high in DONE.
- div -7 / 2, div_ready modelled after 33 cycles -> div_start held 33 cycles; HI=0xFFFF_FFFF (rem -1), LO=0xFFFF_FFFD (-3); stallreq drops on the DONE cycle.
- divu started, annul asserted on cycle 10 -> div_annul 1 cycle; FSM returns to IDLE; hilo_we never asserted; a later div_ready is ignored.
- mult completes with hold=1 for 3 cycles -> hilo_we only on the first DONE cycle; HI/LO stable; IDLE after hold drops.
- With MD_DIVZERO_FAST_EN: div 0x10 / 0 -> no div_start; next cycle hilo_we=1, HI=0x10, LO=0xFFFF_FFFF. Without the macro: div_start asserts and the bench sees the divider's result.
